btn_conditioner: RTL



---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_chan.sv | 111 +++++++++++
 rtl/btn_conditioner.sv | 38 +++
 3 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared defaults and helpers for the btn_conditioner front-panel
// input conditioner (btn_chan per-channel logic, btn_conditioner top).
package btn_pkg;

    // Default configuration: four buttons, 4-sample debounce,
    // first auto-repeat 10 cycles after the press, then every 3 cycles.
    localparam int BTN_N_DEF          = 4;
    localparam int BTN_DB_DEF         = 4;
    localparam int BTN_RPT_DELAY_DEF  = 10;
    localparam int BTN_RPT_PERIOD_DEF = 3;

    // Counter width needed to hold 0..value-1, never narrower than one bit
    // so that degenerate settings (value <= 2) still give a legal vector.
    function automatic int clog2_min1(input int value);
        int w;
        w = (value <= 2) ? 1 : $clog2(value);
        return w;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// btn_chan: one button channel -- 2-flop synchroniser, counter debounce,
// registered rise/fall pulses and, when BTN_CONDITIONER_REPEAT_EN is
// defined, an auto-repeat press stream while the button stays held.
// Without the macro no hold counter exists and o_press equals o_rise.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = BTN_DB_DEF,
    parameter int REPEAT_DELAY  = BTN_RPT_DELAY_DEF,
    parameter int REPEAT_PERIOD = BTN_RPT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_press
);

    localparam int            CW       = clog2_min1(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // Reject illegal configurations at elaboration time.
    if (DB_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 ||
        REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
        $error("btn_chan: illegal DB_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    logic          r_s1;
    logic          r_s2;
    logic          r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rise;
    logic          r_fall;
    logic          w_diff;
    logic          w_flip;

    // The synchronised sample disagrees with the accepted level; once that
    // has held for DB_CYCLES consecutive samples the level flips.
    assign w_diff = (r_s2 != r_state);
    assign w_flip = w_diff && (r_cnt == CNT_LAST);

    // Synchroniser, debounce counter and edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_state <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_rise <= w_flip && r_s2;
            r_fall <= w_flip && !r_s2;
        end
    end

    assign o_level = r_state;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

`ifdef BTN_CONDITIONER_REPEAT_EN
    localparam int            HW          = clog2_min1(REPEAT_DELAY + 1);
    localparam logic [HW-1:0] HCNT_FIRE   = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HCNT_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hnext;
    logic          r_rep;

    assign w_hnext = r_hcnt + 1'b1;

    // Hold counter: restarts at every level flip (so a release in the cycle
    // a repeat is due wins and parks the counter at 0), counts while held,
    // and reloads after each repeat so later pulses come every REPEAT_PERIOD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_rep  <= 1'b0;
        end else begin
            r_rep <= 1'b0;
            if (w_flip) begin
                r_hcnt <= '0;
            end else if (r_state) begin
                if (w_hnext == HCNT_FIRE) begin
                    r_rep  <= 1'b1;
                    r_hcnt <= HCNT_RELOAD;
                end else begin
                    r_hcnt <= w_hnext;
                end
            end
        end
    end

    assign o_press = r_rise | r_rep;
`else
    assign o_press = r_rise;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N independent push-button conditioners (sync, debounce,
// rise/fall pulses, optional auto-repeat press stream). Auto-repeat is
// built only when BTN_CONDITIONER_REPEAT_EN is defined; otherwise press
// equals rise and the repeat parameters are ignored.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N             = BTN_N_DEF,
    parameter int DB_CYCLES     = BTN_DB_DEF,
    parameter int REPEAT_DELAY  = BTN_RPT_DELAY_DEF,
    parameter int REPEAT_PERIOD = BTN_RPT_PERIOD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] press
);

    for (genvar g = 0; g < N; g++) begin : g_chan
        btn_chan #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (btn[g]),
            .o_level (level[g]),
            .o_rise  (rise[g]),
            .o_fall  (fall[g]),
            .o_press (press[g])
        );
    end

endmodule
